// File: rtl/serial_arbiter.sv
// serial_arbiter
//   Four-channel round-robin arbiter that feeds one byte per frame to a
//   downstream serializer. Frame = LOAD (1 cycle) + SHIFT (FRAME_BITS cycles)
//   + GAP (GAP cycles) + at least one IDLE cycle for the next arbitration.
//
// Parameters
//   FRAME_BITS : shift cycles per loaded byte (1..255)
//   GAP        : idle cycles after each frame (0..15)
//
// Ports
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   en       : arbitration enable; low only blocks new grants
//   req      : per-channel level request, bit i = channel i
//   data_in  : per-channel byte, channel i on [8i+7:8i]
//   gnt      : one-hot, one-cycle grant (during LOAD only)
//   ser_load : one-cycle load pulse to the serializer
//   ser_data : captured byte, stable from LOAD until the next LOAD
//   busy     : high from LOAD through the last GAP cycle
//   last_ch  : most recently granted channel (3 after reset)
module serial_arbiter #(
  parameter int unsigned FRAME_BITS = 8,
  parameter int unsigned GAP        = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  req,
  input  logic [31:0] data_in,
  output logic [3:0]  gnt,
  output logic        ser_load,
  output logic [7:0]  ser_data,
  output logic        busy,
  output logic [1:0]  last_ch
);

  localparam logic [7:0] FRAME_CNT = 8'(FRAME_BITS);
  localparam logic [7:0] GAP_CNT   = 8'(GAP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] sel_ch;     // channel picked in IDLE, committed to last_ch when LOAD ends

  logic       pick_valid;
  logic [1:0] pick_ch;
  logic [1:0] idx;

  // Round-robin search starting one past last_ch; 2-bit wrap gives mod 4.
  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = '0;
    idx        = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last_ch + 2'(k);
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick_ch    = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      sel_ch   <= '0;
      gnt      <= '0;
      ser_load <= 1'b0;
      ser_data <= '0;
      busy     <= 1'b0;
      last_ch  <= 2'd3;
    end else begin
      gnt      <= '0;
      ser_load <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en && pick_valid) begin
            state    <= S_LOAD;
            sel_ch   <= pick_ch;
            ser_data <= data_in[{pick_ch, 3'b000} +: 8];
            gnt      <= 4'b0001 << pick_ch;
            ser_load <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          last_ch <= sel_ch;
          cnt     <= FRAME_CNT;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (cnt == 8'd1) begin
            if (GAP_CNT != 8'd0) begin
              state <= S_GAP;
              cnt   <= GAP_CNT;
            end else begin
              state <= S_IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_GAP: begin
          if (cnt == 8'd1) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_arbiter.sv
// tb_serial_arbiter
//   Directed bench for serial_arbiter. A cycle-countdown model (grant, then
//   busy for FRAME_BITS+GAP+1 cycles) is compared with the DUT on every
//   negative clock edge; directed scenarios add literal expectations.
//   A second instance with FRAME_BITS=1, GAP=0 checks the short frame.
module tb_serial_arbiter;

  localparam int FB = 8;
  localparam int GP = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  gnt;
  logic        ser_load;
  logic [7:0]  ser_data;
  logic        busy;
  logic [1:0]  last_ch;

  logic        rst2_n = 1'b0;
  logic [3:0]  gnt2;
  logic        ser_load2;
  logic [7:0]  ser_data2;
  logic        busy2;
  logic [1:0]  last_ch2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit cmp_on   = 1'b0;
  bit mon_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_arbiter #(.FRAME_BITS(FB), .GAP(GP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .data_in(data_in),
    .gnt(gnt), .ser_load(ser_load), .ser_data(ser_data), .busy(busy),
    .last_ch(last_ch)
  );

  serial_arbiter #(.FRAME_BITS(1), .GAP(0)) dut2 (
    .clk(clk), .rst_n(rst2_n), .en(1'b1), .req(4'hF), .data_in(32'h44332211),
    .gnt(gnt2), .ser_load(ser_load2), .ser_data(ser_data2), .busy(busy2),
    .last_ch(last_ch2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int rr_pick(input logic [3:0] r, input logic [1:0] last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(int'(last) + k) % 4]) return (int'(last) + k) % 4;
    end
    return 0;
  endfunction

  logic [3:0] m_gnt  = '0;
  logic       m_load = 1'b0;
  logic [7:0] m_data = '0;
  logic [1:0] m_last = 2'd3;
  logic [1:0] m_sel  = '0;
  int         m_left = 0;   // cycles of busy remaining, counting the current one

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_gnt  <= '0;
      m_load <= 1'b0;
      m_data <= '0;
      m_last <= 2'd3;
      m_sel  <= '0;
      m_left <= 0;
    end else begin
      if (m_load) m_last <= m_sel;
      m_load <= 1'b0;
      m_gnt  <= '0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
      end else if (en && req != 4'b0000) begin
        m_gnt  <= 4'b0001 << rr_pick(req, m_last);
        m_load <= 1'b1;
        m_data <= data_in[8*rr_pick(req, m_last) +: 8];
        m_sel  <= 2'(rr_pick(req, m_last));
        m_left <= FB + GP + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cyc_gnt", gnt, m_gnt);
      check("cyc_ser_load", ser_load, m_load);
      check("cyc_ser_data", ser_data, m_data);
      check("cyc_busy", busy, (m_left != 0));
      check("cyc_last_ch", last_ch, m_last);
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_load(input string name);
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (ser_load) return;
    end
    check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 50; i++) begin
      if (!busy) return;
      step(1);
    end
    check({name, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  // ---------------- short-frame instance monitor ----------------
  initial begin
    int t2[6];
    logic [3:0] g2[6];
    logic [3:0] g2_exp[6];
    int n2;
    n2 = 0;
    g2_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    while (!rst2_n) @(negedge clk);
    for (int i = 0; i < 60 && n2 < 6; i++) begin
      @(negedge clk);
      if (ser_load2) begin
        t2[n2] = cyc;
        g2[n2] = gnt2;
        n2++;
      end
    end
    check("t35_load_count", n2, 6);
    for (int k = 0; k < n2; k++) begin
      check("t35_gnt_order", g2[k], g2_exp[k]);
      if (k > 0) check("t35_period", t2[k] - t2[k-1], 3);
    end
    mon_done = 1'b1;
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int t[5];
    logic [3:0] g[5];
    logic [7:0] d[5];
    logic [3:0] g_exp[5];
    logic [7:0] d_exp[5];
    int bcnt;
    int lcnt;
    g_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    d_exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};

    step(3);
    cmp_on = 1'b1;
    check("rst_last_ch", last_ch, 2'd3);
    check("rst_busy", busy, 1'b0);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_ser_data", ser_data, 8'h00);

    // single request
    rst_n = 1'b1; rst2_n = 1'b1; en = 1'b1;
    req = 4'b0001; data_in = 32'h0000006E;
    step(1);
    check("t30_load", ser_load, 1'b1);
    check("t30_gnt", gnt, 4'b0001);
    check("t30_data", ser_data, 8'h6E);
    req = 4'b0000;
    data_in = 32'h000000FF;
    bcnt = 0;
    for (int i = 0; i < 30 && busy; i++) begin
      bcnt++;
      step(1);
    end
    check("t30_busy_len", bcnt, 10);
    check("t30_data_held", ser_data, 8'h6E);

    // all requesting, from reset
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    req = 4'hF; data_in = 32'hA3A2A1A0;
    for (int k = 0; k < 5; k++) begin
      wait_load("t31");
      t[k] = cyc; g[k] = gnt; d[k] = ser_data;
    end
    req = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      check("t31_gnt_order", g[k], g_exp[k]);
      check("t31_data", d[k], d_exp[k]);
      if (k > 0) check("t31_period", t[k] - t[k-1], 11);
    end
    wait_idle("t31");
    check("t31_last_ch", last_ch, 2'd0);

    // wrap and skip: get last_ch=2 then req=0011
    req = 4'b0100;
    wait_load("t32a");
    check("t32_setup_gnt", gnt, 4'b0100);
    req = 4'b0000;
    wait_idle("t32a");
    check("t32_last_ch", last_ch, 2'd2);
    req = 4'b0011;
    wait_load("t32b");
    check("t32_first", gnt, 4'b0001);
    wait_load("t32c");
    check("t32_second", gnt, 4'b0010);
    req = 4'b0000;
    wait_idle("t32c");

    // en gating mid-frame
    req = 4'b0100;
    wait_load("t33a");
    check("t33_first_gnt", gnt, 4'b0100);
    step(2);
    en = 1'b0;
    wait_idle("t33");
    lcnt = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (ser_load) lcnt++;
    end
    check("t33_no_load_while_off", lcnt, 0);
    en = 1'b1;
    step(1);
    check("t33_load_after_en", ser_load, 1'b1);
    check("t33_gnt_after_en", gnt, 4'b0100);
    req = 4'b0000;
    wait_idle("t33b");

    // reset mid-frame: grant ch0, reset during SHIFT cycle 4, then req=0011
    req = 4'b0001;
    wait_load("t34a");
    check("t34_setup_gnt", gnt, 4'b0001);
    step(4);
    rst_n = 1'b0;
    req = 4'b0011;
    #1;
    check("t34_rst_load", ser_load, 1'b0);
    check("t34_rst_busy", busy, 1'b0);
    check("t34_rst_gnt", gnt, 4'b0000);
    check("t34_rst_last_ch", last_ch, 2'd3);
    step(1);
    rst_n = 1'b1;
    step(1);
    check("t34_post_load", ser_load, 1'b1);
    check("t34_post_gnt", gnt, 4'b0001);
    req = 4'b0000;
    wait_idle("t34");

    for (int i = 0; i < 100 && !mon_done; i++) step(1);
    if (!mon_done) check("t35_monitor_timeout", 32'd0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
